// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60 timing defaults, derived window origins and read-FSM encoding.
// Extends the LCD parameter set used by the display path.
package vga_timing_gen_pkg;

  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_H_DISP   = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;
  localparam int DEF_V_DISP   = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_PREFETCH = 2;
  localparam bit DEF_SYNC_POL = 1'b0;

  localparam int CNT_W = 12;

  function automatic int axis_total(input int sync, input int back, input int disp, input int front);
    return sync + back + disp + front;
  endfunction

  localparam int H_TOTAL = axis_total(DEF_H_SYNC, DEF_H_BACK, DEF_H_DISP, DEF_H_FRONT);
  localparam int V_TOTAL = axis_total(DEF_V_SYNC, DEF_V_BACK, DEF_V_DISP, DEF_V_FRONT);
  localparam int HA      = DEF_H_SYNC + DEF_H_BACK;
  localparam int VA      = DEF_V_SYNC + DEF_V_BACK;

  typedef enum logic {
    WAIT_RDY = 1'b0,
    RUN      = 1'b1
  } rd_state_t;

endpackage

// File: rtl/vga_timing_gen_axis_cnt.sv
// One raster axis: wrapping counter plus registered sync, active-position and read-window decode.
// Outputs are decoded from the next count so they line up with the registered count.
module vga_axis_cnt
  import vga_timing_gen_pkg::*;
#(
  parameter int TOTAL     = 800,
  parameter int SYNC      = 96,
  parameter int ACT_START = 144,
  parameter int ACT_LEN   = 640,
  parameter int RD_START  = 142,
  parameter int RD_END    = 782,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic [CNT_W-1:0] pos,
  output logic             sync,
  output logic             rd_win_nxt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] S_END = CNT_W'(SYNC);
  localparam logic [CNT_W-1:0] A_BEG = CNT_W'(ACT_START);
  localparam logic [CNT_W-1:0] A_END = CNT_W'(ACT_START + ACT_LEN);
  localparam logic [CNT_W-1:0] R_BEG = CNT_W'(RD_START);
  localparam logic [CNT_W-1:0] R_END = CNT_W'(RD_END);

  logic [CNT_W-1:0] cnt_nxt;
  logic             act_nxt;

  always_comb begin
    wrap    = en && (cnt == LAST);
    cnt_nxt = cnt;
    if (wrap)
      cnt_nxt = '0;
    else if (en)
      cnt_nxt = cnt + CNT_W'(1);
    act_nxt    = (cnt_nxt >= A_BEG) && (cnt_nxt < A_END);
    rd_win_nxt = (cnt_nxt >= R_BEG) && (cnt_nxt < R_END);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      pos  <= '0;
      sync <= SYNC_POL;
    end else begin
      cnt  <= cnt_nxt;
      pos  <= act_nxt ? (cnt_nxt - A_BEG) : '0;
      sync <= (cnt_nxt < S_END) ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing with a read-FIFO prefetch strobe leading the display window by PREFETCH clocks.
// Reads are enabled per frame only; readiness is sampled at the frame boundary, underflow is sticky.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int H_DISP   = DEF_H_DISP,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int V_DISP   = DEF_V_DISP,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int PREFETCH = DEF_PREFETCH,
  parameter bit SYNC_POL = DEF_SYNC_POL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rfifo_rd_ready,
  input  logic             underflow_clr,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic [CNT_W-1:0] lcd_x,
  output logic [CNT_W-1:0] lcd_y,
  output logic             lcd_hs,
  output logic             lcd_vs,
  output logic             rfifo_rd_req,
  output logic             frame_start,
  output logic             underflow
);

  localparam int HT  = axis_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
  localparam int VT  = axis_total(V_SYNC, V_BACK, V_DISP, V_FRONT);
  localparam int HAO = H_SYNC + H_BACK;
  localparam int VAO = V_SYNC + V_BACK;

  logic      h_wrap, v_wrap;
  logic      h_rd_nxt, v_rd_nxt;
  rd_state_t state;

  vga_axis_cnt #(
    .TOTAL(HT), .SYNC(H_SYNC), .ACT_START(HAO), .ACT_LEN(H_DISP),
    .RD_START(HAO - PREFETCH), .RD_END(HAO + H_DISP - PREFETCH), .SYNC_POL(SYNC_POL)
  ) u_h_axis (
    .clk(clk), .rst(rst), .en(1'b1),
    .cnt(hcnt), .wrap(h_wrap), .pos(lcd_x), .sync(lcd_hs), .rd_win_nxt(h_rd_nxt)
  );

  vga_axis_cnt #(
    .TOTAL(VT), .SYNC(V_SYNC), .ACT_START(VAO), .ACT_LEN(V_DISP),
    .RD_START(VAO), .RD_END(VAO + V_DISP), .SYNC_POL(SYNC_POL)
  ) u_v_axis (
    .clk(clk), .rst(rst), .en(h_wrap),
    .cnt(vcnt), .wrap(v_wrap), .pos(lcd_y), .sync(lcd_vs), .rd_win_nxt(v_rd_nxt)
  );

  // The cycle right after reset also sits at (0,0), so it counts as a frame boundary for the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= WAIT_RDY;
      rfifo_rd_req <= 1'b0;
      frame_start  <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (hcnt == '0 && vcnt == '0)
        state <= rfifo_rd_ready ? RUN : WAIT_RDY;
      rfifo_rd_req <= (state == RUN) && h_rd_nxt && v_rd_nxt;
      frame_start  <= h_wrap && v_wrap;
      if (rfifo_rd_req && !rfifo_rd_ready)
        underflow <= 1'b1;
      else if (underflow_clr)
        underflow <= 1'b0;
    end
  end

endmodule
